// File: rtl/cpu_fetch_seq_pkg.sv
// Shared instruction-set constants for the MiniSoC fetch path: opcodes,
// the fetch step size and the sequencer state encoding.
package cpu_fetch_seq_pkg;

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_JMP  = 8'h05,
    OP_INIT = 8'hFF
  } opcode_e;

  // Three instruction words of 4 bytes each.
  localparam int unsigned FETCH_STEP_SIZE = 12;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_F_OP  = 3'd1;
  localparam logic [2:0] ST_F_A   = 3'd2;
  localparam logic [2:0] ST_F_B   = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;

endpackage

// File: rtl/cpu_fetch_seq_if.sv
// Memory-read and exec-unit signals of the fetch sequencer, bundled so the
// sequencer (master) and its memory/exec neighbours (slave) share one port.
interface cpu_fetch_seq_if #(
  parameter int unsigned WIDTH = 32
);
  // Read handshake: mem_req_o rises with a stable mem_addr_o and stays high,
  // address unchanged, until a cycle where mem_ack_i is sampled high; that
  // cycle transfers mem_rdata_i. mem_ack_i has no meaning while mem_req_o is low.
  logic             enable_i;
  logic             mem_req_o;
  logic [WIDTH-1:0] mem_addr_o;
  logic             mem_ack_i;
  logic [WIDTH-1:0] mem_rdata_i;
  logic [WIDTH-1:0] opcode_o;
  logic [WIDTH-1:0] opa_o;
  logic [WIDTH-1:0] opb_o;
  logic             fetch_done_o;
  logic             exec_done_i;
  logic             isjcc_i;
  logic [WIDTH-1:0] newpc_i;
  logic [WIDTH-1:0] pc_o;
  logic             busy_o;
  logic [WIDTH-1:0] retired_o;
  logic [2:0]       state_dbg;

  modport master (
    input  enable_i, mem_ack_i, mem_rdata_i, exec_done_i, isjcc_i, newpc_i,
    output mem_req_o, mem_addr_o, opcode_o, opa_o, opb_o, fetch_done_o,
           pc_o, busy_o, retired_o, state_dbg
  );

  modport slave (
    output enable_i, mem_ack_i, mem_rdata_i, exec_done_i, isjcc_i, newpc_i,
    input  mem_req_o, mem_addr_o, opcode_o, opa_o, opb_o, fetch_done_o,
           pc_o, busy_o, retired_o, state_dbg
  );
endinterface

// File: rtl/cpu_pc_reg.sv
// Program counter with step/jump selection and the retired-instruction counter.
// The jump decision is captured when execution completes and applied one cycle later.
module cpu_pc_reg
  import cpu_fetch_seq_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(FETCH_STEP_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic             is_jump,
  input  logic [WIDTH-1:0] jump_pc,
  input  logic             advance,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] retired
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             jump_q;
  logic [WIDTH-1:0] target_q;

  // Jump targets are used verbatim; sums simply wrap at WIDTH bits.
  assign next_pc = jump_q ? target_q : pc + STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      retired  <= '0;
      jump_q   <= 1'b0;
      target_q <= '0;
    end else begin
      if (sample) begin
        jump_q   <= is_jump;
        target_q <= jump_pc;
      end
      if (advance) begin
        pc      <= next_pc;
        retired <= retired + ONE;
      end
    end
  end
endmodule

// File: rtl/cpu_fetch_seq.sv
// Instruction sequencer: fetches each 3-word instruction over the read handshake,
// strobes it to the exec unit, waits for completion, then steps or redirects the PC.
module cpu_fetch_seq
  import cpu_fetch_seq_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      WORD_BYTES = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  cpu_fetch_seq_if.master bus
);
  localparam logic [WIDTH-1:0] OFS_A = WIDTH'(WORD_BYTES);
  localparam logic [WIDTH-1:0] OFS_B = WIDTH'(2 * WORD_BYTES);
  localparam logic [WIDTH-1:0] STEP  = WIDTH'(3 * WORD_BYTES);

  logic [2:0]       state;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] opcode;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             fetch_done;
  logic             busy;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] retired;
  logic             accept;
  logic             sample;
  logic             advance;

  assign accept  = mem_req & bus.mem_ack_i;
  assign sample  = (state == ST_WAIT) & bus.exec_done_i;
  assign advance = (state == ST_NEXT);

  cpu_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .STEP     (STEP)
  ) u_pc_reg (
    .clk     (clk_i),
    .rst     (rst_i),
    .sample  (sample),
    .is_jump (bus.isjcc_i),
    .jump_pc (bus.newpc_i),
    .advance (advance),
    .pc      (pc),
    .next_pc (next_pc),
    .retired (retired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      opcode     <= '0;
      opa        <= '0;
      opb        <= '0;
      fetch_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.enable_i) begin
            state    <= ST_F_OP;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        ST_F_OP: begin
          if (accept) begin
            opcode   <= bus.mem_rdata_i;
            mem_addr <= pc + OFS_A;
            state    <= ST_F_A;
          end
        end
        ST_F_A: begin
          if (accept) begin
            opa      <= bus.mem_rdata_i;
            mem_addr <= pc + OFS_B;
            state    <= ST_F_B;
          end
        end
        ST_F_B: begin
          if (accept) begin
            opb        <= bus.mem_rdata_i;
            mem_req    <= 1'b0;
            fetch_done <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        // ISSUE always passes through WAIT, so completion is never taken
        // in the same cycle the exec unit first sees fetch_done.
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.exec_done_i) state <= ST_NEXT;
        end
        ST_NEXT: begin
          mem_addr <= next_pc;
          if (bus.enable_i) begin
            state   <= ST_F_OP;
            mem_req <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.opcode_o     = opcode;
  assign bus.opa_o        = opa;
  assign bus.opb_o        = opb;
  assign bus.fetch_done_o = fetch_done;
  assign bus.pc_o         = pc;
  assign bus.busy_o       = busy;
  assign bus.retired_o    = retired;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Bench for cpu_fetch_seq: a memory/exec responder driven cycle by cycle against
// an instruction-level model of PC, retired count, fetch addresses and latched words.
module tb_cpu_fetch_seq;
  import cpu_fetch_seq_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] RPC = 32'h0;

  logic clk = 1'b0;
  logic rst;

  cpu_fetch_seq_if #(.WIDTH(W)) bus ();

  cpu_fetch_seq #(
    .WIDTH      (W),
    .RESET_PC   (RPC),
    .WORD_BYTES (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard and instruction-level model
  int n_checks = 0;
  int n_err    = 0;
  int cyc;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem_ovr[logic [W-1:0]];
  logic [W-1:0] m_pc, m_ret, m_opc, m_opa, m_opb;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [W-1:0] latch_val(input int idx);
    case (idx)
      0:       return bus.opcode_o;
      1:       return bus.opa_o;
      default: return bus.opb_o;
    endcase
  endfunction

  function automatic logic [W-1:0] model_latch(input int idx);
    case (idx)
      0:       return m_opc;
      1:       return m_opa;
      default: return m_opb;
    endcase
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_req"},        bus.mem_req_o, 0);
    check({pfx, "_addr"},       bus.mem_addr_o, RPC);
    check({pfx, "_pc"},         bus.pc_o, RPC);
    check({pfx, "_opcode"},     bus.opcode_o, 0);
    check({pfx, "_opa"},        bus.opa_o, 0);
    check({pfx, "_opb"},        bus.opb_o, 0);
    check({pfx, "_fetch_done"}, bus.fetch_done_o, 0);
    check({pfx, "_busy"},       bus.busy_o, 0);
    check({pfx, "_retired"},    bus.retired_o, 0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_req",  bus.mem_req_o, 0);
      check("idle_busy", bus.busy_o, 0);
      check("idle_pc",   bus.pc_o, m_pc);
    end
  endtask

  // Called at a negedge where the request for the next queued address should be up.
  task automatic fetch_beat(input int delay, input int idx, output logic [W-1:0] word);
    logic [W-1:0] a;
    a    = exp_q.pop_front();
    word = mem_word(a);
    check("req", bus.mem_req_o, 1);
    check("addr", bus.mem_addr_o, a);
    for (int k = 0; k < delay; k++) begin
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = $urandom;
      @(negedge clk);
      cyc++;
      check("req_hold", bus.mem_req_o, 1);
      check("addr_hold", bus.mem_addr_o, a);
      check("latch_hold", latch_val(idx), model_latch(idx));
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = word;
    @(negedge clk);
    cyc++;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = $urandom;
    check("latch", latch_val(idx), word);
  endtask

  task automatic start_run();
    bus.enable_i = 1'b1;
    @(negedge clk);
    check("start_busy", bus.busy_o, 1);
  endtask

  // One whole instruction, from its F_OP cycle to the cycle after NEXT.
  task automatic run_instr(input int d0, input int d1, input int d2, input int dx,
                           input logic jmp, input logic [W-1:0] tgt, input logic en_next);
    logic [W-1:0] w;
    logic [W-1:0] npc;
    cyc = 0;
    exp_q.push_back(m_pc);
    exp_q.push_back(m_pc + 32'd4);
    exp_q.push_back(m_pc + 32'd8);
    fetch_beat(d0, 0, w); m_opc = w;
    fetch_beat(d1, 1, w); m_opa = w;
    bus.enable_i = en_next;
    fetch_beat(d2, 2, w); m_opb = w;
    check("issue_strobe", bus.fetch_done_o, 1);
    check("issue_req", bus.mem_req_o, 0);
    check("issue_opcode", bus.opcode_o, m_opc);
    check("issue_opa", bus.opa_o, m_opa);
    check("issue_opb", bus.opb_o, m_opb);
    bus.exec_done_i = (dx == 0);
    bus.isjcc_i     = 1'($urandom_range(0, 1));
    bus.newpc_i     = $urandom;
    bus.mem_ack_i   = 1'($urandom_range(0, 1));
    for (int i = 0; i <= dx; i++) begin
      @(negedge clk);
      cyc++;
      check("wait_strobe", bus.fetch_done_o, 0);
      check("wait_req", bus.mem_req_o, 0);
      check("wait_busy", bus.busy_o, 1);
      check("wait_opa", bus.opa_o, m_opa);
      bus.mem_ack_i   = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = $urandom;
      if (i == dx) begin
        bus.exec_done_i = 1'b1;
        bus.isjcc_i     = jmp;
        bus.newpc_i     = tgt;
      end else begin
        bus.isjcc_i = 1'($urandom_range(0, 1));
        bus.newpc_i = $urandom;
      end
    end
    @(negedge clk);
    cyc++;
    bus.mem_ack_i = 1'b0;
    bus.isjcc_i   = 1'($urandom_range(0, 1));
    bus.newpc_i   = $urandom;
    check("next_pc_hold", bus.pc_o, m_pc);
    check("next_opcode", bus.opcode_o, m_opc);
    npc   = jmp ? tgt : m_pc + 32'd12;
    m_pc  = npc;
    m_ret = m_ret + 32'd1;
    @(negedge clk);
    cyc++;
    check("pc", bus.pc_o, m_pc);
    check("retired", bus.retired_o, m_ret);
    check("busy_after", bus.busy_o, en_next);
    check("req_after", bus.mem_req_o, en_next);
    if (en_next) check("addr_next", bus.mem_addr_o, m_pc);
    check("cycles", cyc, 6 + d0 + d1 + d2 + dx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] tgt;
    rst             = 1'b1;
    bus.enable_i    = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    bus.exec_done_i = 1'b0;
    bus.isjcc_i     = 1'b0;
    bus.newpc_i     = '0;
    m_pc = RPC; m_ret = '0; m_opc = '0; m_opa = '0; m_opb = '0;

    mem_ovr[32'h00] = 32'h00; mem_ovr[32'h04] = 32'h05; mem_ovr[32'h08] = 32'h03;
    mem_ovr[32'h0C] = 32'h05; mem_ovr[32'h10] = 32'h40; mem_ovr[32'h14] = 32'h00;
    mem_ovr[32'h40] = 32'(OP_INIT); mem_ovr[32'h44] = 32'h1; mem_ovr[32'h48] = 32'h2;

    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    idle_check(3);

    // Plain instruction, jump, stalled INIT, jump to the top of the address space, wrap
    start_run();
    run_instr(0, 0, 0, 0, 1'b0, '0, 1'b1);
    run_instr(0, 0, 0, 0, 1'b1, 32'h40, 1'b1);
    run_instr(0, 4, 0, 10, 1'b0, '0, 1'b1);
    run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'b1, 32'hFFFF_FFF8, 1'b1);
    run_instr(1, 0, 2, 0, 1'b0, '0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      tgt = $urandom;
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)), tgt, 1'b1);
    end

    // Enable dropped during F_B: instruction completes, then IDLE
    run_instr(0, 0, 0, 1, 1'b0, '0, 1'b0);
    idle_check(5);

    // Reset during F_A while an ack is being presented
    start_run();
    exp_q.delete();
    exp_q.push_back(m_pc);
    fetch_beat(0, 0, w);
    check("fa_addr", bus.mem_addr_o, m_pc + 32'd4);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = mem_word(m_pc + 32'd4);
    bus.enable_i    = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ack_i = 1'b0;
    exp_q.delete();
    m_pc = RPC; m_ret = '0; m_opc = '0; m_opa = '0; m_opb = '0;
    check_reset("post_rst");
    idle_check(3);

    start_run();
    run_instr(0, 0, 0, 0, 1'b0, '0, 1'b0);
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
